key_debounce_fsm: RTL
=====================

// Module: key_debounce_fsm
// PURPOSE
//   Consumer side of the key edge-detect stage: takes the one-cycle H2L_Sig/L2H_Sig
//   edge pulses from the key pin edge detector and converts them into a debounced key state.
//   Also emits press/release/long-press/auto-repeat event pulses for downstream control logic.
//   Sits between the key edge detector and the application FSMs (LED, counter, menu).
// PARAMETERS
//   T1MS        16'd49_999  CLK cycles per 1 ms minus 1 (50 MHz XTAL)
//   DEBOUNCE_MS 10'd10      press/release settle time in ms (>=1)
//   LONG_MS     10'd1000    hold time in HELD before long-press fires (>=1)
//   REPEAT_MS   10'd200     auto-repeat period after long-press (>=1)
// PORTS
//   CLK           in   1  system clock
//   RST_N         in   1  reset; asynchronous, active-low
//   H2L_Sig       in   1  1-cycle pulse: pin fell (key pressed, active-low key)
//   L2H_Sig       in   1  1-cycle pulse: pin rose (key released)
//   Key_Out       out  1  debounced key state, 1 = pressed
//   Press_Pulse   out  1  1-cycle pulse on debounced press
//   Release_Pulse out  1  1-cycle pulse on debounced release
//   Long_Pulse    out  1  1-cycle pulse when hold reaches LONG_MS
//   Repeat_Pulse  out  1  1-cycle pulse every REPEAT_MS while held past long-press
// BEHAVIOUR
//   Reset (RST_N=0, async): state=IDLE, counters=0, all outputs 0. All outputs registered.
//   Timebase: cyc (16b) and ms (10b) counters, both cleared on every state transition.
//     Each cycle cyc+1; at cyc==T1MS: cyc<=0, ms<=ms+1.
//     "N ms expiry" = cycle where cyc==T1MS && ms==N-1, i.e. exactly N*(T1MS+1) cycles
//     after state entry.
//   States / transitions (edges sampled every cycle; expiry and edge in same cycle: edge wins):
//     IDLE       : H2L -> PRESS_DB. L2H ignored.
//     PRESS_DB   : L2H -> IDLE (bounce, no pulse). DEBOUNCE_MS expiry -> HELD.
//                  H2L ignored (no counter restart).
//     HELD       : L2H -> RELEASE_DB. LONG_MS expiry -> REPEAT.
//     REPEAT     : L2H -> RELEASE_DB. REPEAT_MS expiry -> stay, counters clear.
//     RELEASE_DB : H2L -> HELD (bounce; no pulses; long-press timing restarts).
//                  DEBOUNCE_MS expiry -> IDLE.
//   Pulses are asserted for exactly the first cycle after the causing transition/expiry:
//     PRESS_DB->HELD: Press_Pulse=1, Key_Out<=1.
//     RELEASE_DB->IDLE: Release_Pulse=1, Key_Out<=0.
//     HELD->REPEAT: Long_Pulse=1. Each REPEAT expiry: Repeat_Pulse=1.
//   Key_Out = 1 in HELD, REPEAT and RELEASE_DB; 0 in IDLE and PRESS_DB.
//   At most one pulse output is high in any cycle.
//   H2L and L2H high in same cycle: treated as no edge (state and counters unchanged).
//   Async reset mid-operation: immediate return to IDLE, outputs 0.
//   Any pending pulse is lost; the next press requires a full debounce.
// TESTING (sim params T1MS=9, DEBOUNCE_MS=3, LONG_MS=8, REPEAT_MS=2 -> 10 cycles/ms)
//   1 H2L at cycle t, no more edges -> Press_Pulse=1 at t+31 only, Key_Out=1 from t+31.
//   2 H2L at t, L2H at t+10 -> no pulses ever, Key_Out stays 0, state IDLE at t+11.
//   3 press then hold -> Long_Pulse 80 cycles after Press_Pulse.
//     Then Repeat_Pulse every 20 cycles; exactly one per window.
//   4 In HELD: L2H, H2L +5 cycles, L2H +5 cycles -> Key_Out stays 1.
//     Single Release_Pulse 31 cycles after the final L2H, then Key_Out=0.
//   5 RST_N low during REPEAT -> all outputs 0 same cycle.
//     After release of reset, H2L -> Press_Pulse 31 cycles later.
//   6 H2L&L2H together in IDLE and in HELD -> no state change, no pulse.
//     Also: L2H in IDLE ignored.

Source files
------------

// File: rtl/key_debounce_fsm.sv
// Debounced key state machine fed by one-cycle pin edge pulses.
// Produces a stable key level plus press, release, long-press and auto-repeat event pulses.
module key_debounce_fsm #(
    parameter logic [15:0] T1MS        = 16'd49_999,
    parameter logic [9:0]  DEBOUNCE_MS = 10'd10,
    parameter logic [9:0]  LONG_MS     = 10'd1000,
    parameter logic [9:0]  REPEAT_MS   = 10'd200
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic H2L_Sig,
    input  logic L2H_Sig,
    output logic Key_Out,
    output logic Press_Pulse,
    output logic Release_Pulse,
    output logic Long_Pulse,
    output logic Repeat_Pulse
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        HELD,
        REPEAT,
        RELEASE_DB
    } state_t;

    state_t      state;
    logic [15:0] cyc;
    logic [9:0]  ms;

    logic tick;
    logic fall;
    logic rise;
    logic both;
    logic db_expiry;
    logic long_expiry;
    logic repeat_expiry;

    // An expiry is the last cycle of the Nth millisecond since the state was entered.
    assign tick          = (cyc == T1MS);
    assign db_expiry     = tick && (ms == DEBOUNCE_MS - 10'd1);
    assign long_expiry   = tick && (ms == LONG_MS - 10'd1);
    assign repeat_expiry = tick && (ms == REPEAT_MS - 10'd1);
    assign fall          = H2L_Sig && !L2H_Sig;
    assign rise          = L2H_Sig && !H2L_Sig;
    assign both          = H2L_Sig && L2H_Sig;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state         <= IDLE;
            cyc           <= 16'd0;
            ms            <= 10'd0;
            Key_Out       <= 1'b0;
            Press_Pulse   <= 1'b0;
            Release_Pulse <= 1'b0;
            Long_Pulse    <= 1'b0;
            Repeat_Pulse  <= 1'b0;
        end else begin
            Press_Pulse   <= 1'b0;
            Release_Pulse <= 1'b0;
            Long_Pulse    <= 1'b0;
            Repeat_Pulse  <= 1'b0;
            // Simultaneous edges are ambiguous, so the whole machine freezes for that cycle.
            if (!both) begin
                if (tick) begin
                    cyc <= 16'd0;
                    ms  <= ms + 10'd1;
                end else begin
                    cyc <= cyc + 16'd1;
                end
                unique case (state)
                    IDLE: begin
                        if (fall) begin
                            state <= PRESS_DB;
                            cyc   <= 16'd0;
                            ms    <= 10'd0;
                        end
                    end
                    PRESS_DB: begin
                        if (rise) begin
                            state <= IDLE;
                            cyc   <= 16'd0;
                            ms    <= 10'd0;
                        end else if (db_expiry) begin
                            state       <= HELD;
                            cyc         <= 16'd0;
                            ms          <= 10'd0;
                            Key_Out     <= 1'b1;
                            Press_Pulse <= 1'b1;
                        end
                    end
                    HELD: begin
                        if (rise) begin
                            state <= RELEASE_DB;
                            cyc   <= 16'd0;
                            ms    <= 10'd0;
                        end else if (long_expiry) begin
                            state      <= REPEAT;
                            cyc        <= 16'd0;
                            ms         <= 10'd0;
                            Long_Pulse <= 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (rise) begin
                            state <= RELEASE_DB;
                            cyc   <= 16'd0;
                            ms    <= 10'd0;
                        end else if (repeat_expiry) begin
                            cyc          <= 16'd0;
                            ms           <= 10'd0;
                            Repeat_Pulse <= 1'b1;
                        end
                    end
                    RELEASE_DB: begin
                        if (fall) begin
                            state <= HELD;
                            cyc   <= 16'd0;
                            ms    <= 10'd0;
                        end else if (db_expiry) begin
                            state         <= IDLE;
                            cyc           <= 16'd0;
                            ms            <= 10'd0;
                            Key_Out       <= 1'b0;
                            Release_Pulse <= 1'b1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        cyc     <= 16'd0;
                        ms      <= 10'd0;
                        Key_Out <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
